// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stall-bus indices, NOP encodings and stage actions for pipeline registers
package pipe_stage_reg_pkg;
  localparam int STALL_BUS_W = 6;
  localparam int STAGE_IF = 0;
  localparam int STAGE_ID = 1;
  localparam int STAGE_EX = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB = 4;
  localparam logic ENABLED = 1'b1;
  localparam logic DISABLED = 1'b0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;
  localparam logic ZERO = 1'b0;
  typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_HOLD, ACT_FLUSH} act_e;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall/flush/bubble control and perf counters
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 5,
  parameter int NSRC = 2,
  parameter int STALL_W = 6,
  parameter int STAGE = 2,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic                   clr_cnt,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic                   in_regwe,
  input  logic [NSRC*ADDR_W-1:0] in_srcaddr,
  input  logic [NSRC-1:0]        in_srcen,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_rd,
  output logic                   out_regwe,
  output logic [NSRC*ADDR_W-1:0] out_srcaddr,
  output logic [NSRC-1:0]        out_srcen,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic [CNT_W-1:0]       flush_cnt,
  output logic [CNT_W-1:0]       hold_cnt
);
  if (STAGE + 1 >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
  end
  logic up, dn;
  act_e act;
  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];
  // up=0 with dn=1 is illegal upstream; it falls through to LOAD
  always_comb act = flush ? ACT_FLUSH : (up && !dn) ? ACT_BUBBLE : !up ? ACT_LOAD : ACT_HOLD;
  always_ff @(posedge clk)
    if (rst || act == ACT_FLUSH || act == ACT_BUBBLE) begin
      out_valid   <= FALSE;
      out_data    <= NOP_DATA;
      out_rd      <= '0;
      out_regwe   <= DISABLED;
      out_srcaddr <= '0;
      out_srcen   <= '0;
    end else if (act == ACT_LOAD) begin
      out_valid   <= in_valid;
      out_data    <= in_valid ? in_data : NOP_DATA;
      out_rd      <= in_valid ? in_rd : '0;
      out_regwe   <= in_regwe & in_valid;
      out_srcaddr <= in_valid ? in_srcaddr : '0;
      out_srcen   <= in_srcen & {NSRC{in_valid}};
    end
  sat_counter #(.CNT_W(CNT_W)) u_bubble (.clk(clk), .rst(rst), .clr(clr_cnt), .inc(act == ACT_BUBBLE), .count(bubble_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush  (.clk(clk), .rst(rst), .clr(clr_cnt), .inc(act == ACT_FLUSH),  .count(flush_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_hold   (.clk(clk), .rst(rst), .clr(clr_cnt), .inc(act == ACT_HOLD),   .count(hold_cnt));
endmodule
